note_judge: RTL

- Rhythm-game judgement stage, directly upstream of the score/combo/precision sprite drawer.
- Buffers chart notes per lane and compares lane key presses against song time un_time.
- Grades each note PERFECT / BAD / MISS.
- Accumulates per-frame score, combo and worst-grade totals, then publishes them once per video frame on new_frame for the drawer to add into its running counters.

---
 rtl/note_judge.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/note_judge.sv
// note_judge -- rhythm-game judgement stage.
//
// Buffers chart notes in one FIFO per key lane and grades the head note of
// each lane against the song clock un_time: PERFECT, BAD or MISS. All lanes
// are judged in parallel every cycle. Per-frame score, combo and worst-grade
// totals are accumulated. They are published on each rising edge of
// new_frame, for the downstream score/combo/precision drawer.
//
// Optional build macro: JUDGE_EARLY_MISS_EN. When it is defined, a press that
// arrives between BAD_WIN and 2*BAD_WIN before the head note pops that note
// as MISS. When it is undefined, such a press is ignored.
//
// Ports:
//   clk, reset        system clock; asynchronous active-high reset
//   start             pulse; begin judging (from IDLE or DONE)
//   song_end          pulse; chart exhausted, flush remaining notes as MISS
//   new_frame         frame strobe (level; its rising edge publishes)
//   un_time[15:0]     current song time in ms, monotonic
//   key_press[3:0]    one-cycle press pulse per lane
//   note_valid/lane/time, note_ready   chart-note push handshake
//   score[12:0]       score earned in the last completed frame
//   combo[3:0]        non-miss hits in the last frame, saturating at 15
//   precise[1:0]      worst grade in the last frame: 0 none, 1 PERFECT, 2 BAD, 3 MISS
//   done              high while in the DONE state

// One lane: note FIFO plus head-note grading.
// The lane pops its own head whenever the grade it reports is not none.
module note_judge_lane #(
    parameter int          DEPTH       = 4,
    parameter logic [15:0] PERFECT_WIN = 16'd40,
    parameter logic [15:0] BAD_WIN     = 16'd100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        judge,
    input  logic        flush,
    input  logic        push,
    input  logic [15:0] push_time,
    input  logic [15:0] un_time,
    input  logic        press,
    output logic        empty,
    output logic        full,
    output logic [1:0]  grade
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] G_NONE = 2'd0, G_PERFECT = 2'd1, G_BAD = 2'd2, G_MISS = 2'd3;

    logic [15:0]        mem [DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic [15:0]        head;
    logic [16:0]        now_ext, head_ext, late_lim, mag;
    logic signed [16:0] diff;
    logic               late, pop;

    // The extra pointer bit tells "full" apart from "empty" when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign pop   = (grade != G_NONE);

    always_comb begin
        now_ext  = {1'b0, un_time};
        head_ext = {1'b0, head};
        late_lim = head_ext + {1'b0, BAD_WIN};
        late     = now_ext > late_lim;
        diff     = signed'(now_ext) - signed'(head_ext);
        mag      = diff[16] ? unsigned'(-diff) : unsigned'(diff);
        grade    = G_NONE;
        if (judge && !empty) begin
            // Expiry wins over a same-cycle press; a flush drains one note per cycle.
            if (flush || late) begin
                grade = G_MISS;
            end else if (press) begin
                if (mag <= {1'b0, PERFECT_WIN})
                    grade = G_PERFECT;
                else if (mag <= {1'b0, BAD_WIN})
                    grade = G_BAD;
`ifdef JUDGE_EARLY_MISS_EN
                // A negative diff means the press came before the note time.
                else if (diff[16] && (mag <= {BAD_WIN, 1'b0}))
                    grade = G_MISS;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_time;
    end
endmodule

module note_judge #(
    parameter int          LANES       = 4,
    parameter int          DEPTH       = 4,
    parameter logic [15:0] PERFECT_WIN = 16'd40,
    parameter logic [15:0] BAD_WIN     = 16'd100,
    parameter logic [12:0] PERFECT_PTS = 13'd300,
    parameter logic [12:0] BAD_PTS     = 13'd100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             song_end,
    input  logic             new_frame,
    input  logic [15:0]      un_time,
    input  logic [LANES-1:0] key_press,
    input  logic             note_valid,
    input  logic [1:0]       note_lane,
    input  logic [15:0]      note_time,
    output logic             note_ready,
    output logic [12:0]      score,
    output logic [3:0]       combo,
    output logic [1:0]       precise,
    output logic             done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                  state;
    logic [LANES-1:0]        empty, full, push;
    logic [LANES-1:0][1:0]   grade;
    logic                    judge, flush, frame_q, rise;
    logic [2:0]              n_p, n_b;
    logic [1:0]              worst_next;
    logic [13:0]             pts, score_sum;
    logic [4:0]              combo_sum;
    logic [12:0]             score_acc, score_next;
    logic [3:0]              combo_acc, combo_next;
    logic [1:0]              worst_acc;

    assign judge = (state == S_RUN) || (state == S_FLUSH);
    assign flush = (state == S_FLUSH);
    // Held low during reset so the port reads 0 while reset is asserted.
    assign note_ready = !reset && ((state == S_IDLE) || (state == S_RUN)) && !full[note_lane];
    assign rise = new_frame && !frame_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign push[g] = note_valid && note_ready && (note_lane == 2'(g));
        note_judge_lane #(
            .DEPTH(DEPTH), .PERFECT_WIN(PERFECT_WIN), .BAD_WIN(BAD_WIN)
        ) u_lane (
            .clk(clk), .reset(reset), .judge(judge), .flush(flush),
            .push(push[g]), .push_time(note_time), .un_time(un_time),
            .press(key_press[g]), .empty(empty[g]), .full(full[g]), .grade(grade[g])
        );
    end

    // Combine every lane's verdict for this cycle into the running totals.
    always_comb begin
        n_p        = '0;
        n_b        = '0;
        worst_next = worst_acc;
        for (int i = 0; i < LANES; i++) begin
            if (grade[i] == 2'd1) n_p = n_p + 3'd1;
            if (grade[i] == 2'd2) n_b = n_b + 3'd1;
            if (grade[i] > worst_next) worst_next = grade[i];
        end
        pts        = 14'(n_p) * 14'(PERFECT_PTS) + 14'(n_b) * 14'(BAD_PTS);
        score_sum  = {1'b0, score_acc} + pts;
        score_next = score_sum[13] ? 13'h1fff : score_sum[12:0];
        combo_sum  = {1'b0, combo_acc} + 5'(n_p) + 5'(n_b);
        combo_next = (combo_sum > 5'd15) ? 4'd15 : combo_sum[3:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            frame_q   <= 1'b0;
            score_acc <= '0;
            combo_acc <= '0;
            worst_acc <= '0;
            score     <= '0;
            combo     <= '0;
            precise   <= '0;
        end else begin
            frame_q <= new_frame;
            // The publish includes this cycle's events; the next cycle starts a fresh frame.
            if (rise) begin
                score     <= score_next;
                combo     <= combo_next;
                precise   <= worst_next;
                score_acc <= '0;
                combo_acc <= '0;
                worst_acc <= '0;
            end else if (state == S_DONE && start) begin
                score_acc <= '0;
                combo_acc <= '0;
                worst_acc <= '0;
            end else begin
                score_acc <= score_next;
                combo_acc <= combo_next;
                worst_acc <= worst_next;
            end

            case (state)
                S_IDLE:  if (start)    state <= S_RUN;
                S_RUN:   if (song_end) state <= S_FLUSH;
                S_FLUSH: if (&empty) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE:  if (start) begin
                    state <= S_RUN;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
